// File: rtl/sample_delay_ram_pkg.sv
// Shared constants and helpers for the multi-tap sample delay buffer.
// Latency constant follows SAMPLE_DELAY_RAM_OUTREG_EN.
package sample_delay_ram_pkg;

  localparam int unsigned DATA_WIDTH_DEF    = 16;
  localparam int unsigned ADDRESS_WIDTH_DEF = 10;
  localparam int unsigned NUM_TAPS_DEF      = 2;

`ifdef SAMPLE_DELAY_RAM_OUTREG_EN
  localparam int unsigned OUT_LATENCY = 2;
`else
  localparam int unsigned OUT_LATENCY = 1;
`endif

  // Low bit of slice idx in a bus of width-wide fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sdr_tap_ram.sv
// Simple dual-port block RAM: one write port, one synchronous registered read port.
// Read-during-write to the same address returns the old contents.
module sdr_tap_ram #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_delay_ram.sv
// Multi-tap circular delay buffer with per-tap run-time delay and history-valid flags.
// Optional SAMPLE_DELAY_RAM_OUTREG_EN adds one output register stage.
module sample_delay_ram
  import sample_delay_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned NUM_TAPS      = NUM_TAPS_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic [NUM_TAPS*ADDRESS_WIDTH-1:0] tap_delay,
  output logic                              out_valid,
  output logic [NUM_TAPS*DATA_WIDTH-1:0]    out_data,
  output logic [NUM_TAPS-1:0]               tap_ok
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned AW    = ADDRESS_WIDTH;
  localparam int unsigned FW    = ADDRESS_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  logic                   accept_c;
  logic [AW-1:0]          wr_ptr;
  logic [FW-1:0]          fill_count;
  logic [NUM_TAPS-1:0]    ok_c;
  logic [NUM_TAPS-1:0]    zero_c;
  logic                   valid_q;
  logic [NUM_TAPS-1:0]    ok_q;
  logic [NUM_TAPS-1:0]    byp_q;
  logic [DW-1:0]          byp_data_q;
  logic [NUM_TAPS*DW-1:0] rd_all;
  logic [NUM_TAPS*DW-1:0] data_c;

  assign accept_c = in_valid & ~clear;

  // Write pointer and saturating history depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      fill_count <= '0;
    end else if (in_valid) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (fill_count != FW'(DEPTH)) fill_count <= fill_count + FW'(1);
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    logic [AW-1:0] delay;
    logic [AW-1:0] rd_addr;

    assign delay     = tap_delay[slice_lo(k, AW) +: AW];
    assign rd_addr   = wr_ptr - delay;
    assign ok_c[k]   = FW'(delay) <= fill_count;
    assign zero_c[k] = delay == '0;

    sdr_tap_ram #(
      .DATA_WIDTH   (DW),
      .ADDRESS_WIDTH(AW)
    ) u_ram (
      .clk    (clk),
      .wr_en  (accept_c),
      .wr_addr(wr_ptr),
      .wr_data(in_data),
      .rd_en  (accept_c),
      .rd_addr(rd_addr),
      .rd_data(rd_all[slice_lo(k, DW) +: DW])
    );

    // The RAM read register is the data stage; only the bypass/gating mux follows it.
    assign data_c[slice_lo(k, DW) +: DW] =
      ok_q[k] ? (byp_q[k] ? byp_data_q : rd_all[slice_lo(k, DW) +: DW]) : '0;
  end

  // Per-sample control registered alongside the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ok_q       <= '0;
      byp_q      <= '0;
      byp_data_q <= '0;
    end else begin
      valid_q <= accept_c;
      if (accept_c) begin
        ok_q       <= ok_c;
        byp_q      <= zero_c;
        byp_data_q <= in_data;
      end
    end
  end

`ifdef SAMPLE_DELAY_RAM_OUTREG_EN
  logic                   valid_q2;
  logic [NUM_TAPS*DW-1:0] data_q2;
  logic [NUM_TAPS-1:0]    ok_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q2 <= 1'b0;
      data_q2  <= '0;
      ok_q2    <= '0;
    end else begin
      valid_q2 <= valid_q;
      data_q2  <= data_c;
      ok_q2    <= ok_q;
    end
  end

  assign out_valid = valid_q2;
  assign out_data  = data_q2;
  assign tap_ok    = ok_q2;
`else
  assign out_valid = valid_q;
  assign out_data  = data_c;
  assign tap_ok    = ok_q;
`endif

endmodule
